// File: rtl/fb_port_if.sv
// Bundle of the display-read, pixel-write and RAM-side signals around the framebuffer arbiter.
// slave: the arbiter's view; master: the display, writer and RAM side.
interface fb_port_if #(
  parameter int ADDR_W = 15
) ();
  logic              disp_req;
  logic [ADDR_W-1:0] disp_addr;
  logic              disp_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic              wr_data;
  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic              ram_wdata;
  logic              ram_rdata;

  modport slave (
    input  disp_req, disp_addr, wr_valid, wr_addr, wr_data, ram_rdata,
    output disp_data, wr_ready, ram_addr, ram_we, ram_wdata
  );

  modport master (
    output disp_req, disp_addr, wr_valid, wr_addr, wr_data, ram_rdata,
    input  disp_data, wr_ready, ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/fb_port_arbiter.sv
// Single-port 1-bit framebuffer arbiter: display reads > clear engine > pixel writer.
// Define FB_CLEAR_EN to build the full-buffer clear engine (clr_* ports are tied off otherwise).
module fb_port_arbiter #(
  parameter int   ADDR_W    = 15,
  parameter int   DEPTH     = 19200,
  parameter logic CLEAR_VAL = 1'b0
) (
  input  logic        clk_25,
  input  logic        rst_n,
  fb_port_if.slave    bus,
  input  logic        clr_start,
  output logic        clr_busy,
  output logic        clr_done
);

  localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);

  logic              rd_pend;
  logic              clear_active;
  logic [ADDR_W-1:0] clr_addr;

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend <= 1'b0;
    end else begin
      rd_pend <= bus.disp_req;
    end
  end

  // The RAM output is already a register, so gating it with rd_pend gives a
  // registered, one-cycle-latency pixel that reads black when no fetch is pending.
  assign bus.disp_data = rd_pend & bus.ram_rdata;

  assign bus.wr_ready = rst_n & ~bus.disp_req & ~clear_active;

  always_comb begin
    bus.ram_addr  = bus.disp_addr;
    bus.ram_we    = 1'b0;
    bus.ram_wdata = bus.wr_data;
    if (!bus.disp_req) begin
      if (clear_active) begin
        bus.ram_addr  = clr_addr;
        bus.ram_we    = 1'b1;
        bus.ram_wdata = CLEAR_VAL;
      end else if (bus.wr_valid && rst_n) begin
        bus.ram_addr = bus.wr_addr;
        bus.ram_we   = (bus.wr_addr < DEPTH_A);
      end
    end
  end

`ifdef FB_CLEAR_EN
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] clr_addr_next;
  logic              clr_done_next;
  logic              clr_write;

  assign clear_active = (state == CLEAR);
  assign clr_busy     = clear_active;
  assign clr_write    = clear_active & ~bus.disp_req;

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      clr_addr <= '0;
      clr_done <= 1'b0;
    end else begin
      state    <= state_next;
      clr_addr <= clr_addr_next;
      clr_done <= clr_done_next;
    end
  end

  // Display-granted cycles stall the sweep; the last address returns to IDLE.
  always_comb begin
    state_next    = state;
    clr_addr_next = clr_addr;
    clr_done_next = 1'b0;
    case (state)
      IDLE: begin
        if (clr_start) begin
          state_next    = CLEAR;
          clr_addr_next = '0;
        end
      end
      CLEAR: begin
        if (clr_write) begin
          if (clr_addr == LAST_ADDR) begin
            state_next    = IDLE;
            clr_done_next = 1'b1;
          end else begin
            clr_addr_next = clr_addr + ADDR_W'(1);
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end
`else
  logic unused_clr_start;

  assign unused_clr_start = clr_start;
  assign clear_active     = 1'b0;
  assign clr_addr         = '0;
  assign clr_busy         = 1'b0;
  assign clr_done         = 1'b0;
`endif

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed bench for fb_port_arbiter: vector table for arbitration/read path, hand sequences
// for reset, clr_start handling and (with FB_CLEAR_EN) the clear engine.
module tb_fb_port_arbiter;

  localparam int ADDR_W = 15;
  localparam int DEPTH  = 19200;

  logic clk_25;
  logic rst_n;
  logic clr_start;
  logic clr_busy;
  logic clr_done;

  logic              fill_en;
  logic              fill_val;
  logic              poke_en;
  logic [ADDR_W-1:0] poke_addr;
  logic              poke_val;

  logic mem [0:32767];

  int n_compared   = 0;
  int n_mismatched = 0;

  fb_port_if #(.ADDR_W(ADDR_W)) bus ();

  fb_port_arbiter #(
    .ADDR_W   (ADDR_W),
    .DEPTH    (DEPTH),
    .CLEAR_VAL(1'b0)
  ) dut (
    .clk_25   (clk_25),
    .rst_n    (rst_n),
    .bus      (bus),
    .clr_start(clr_start),
    .clr_busy (clr_busy),
    .clr_done (clr_done)
  );

  initial clk_25 = 1'b0;
  always #20 clk_25 = ~clk_25;

  // Synchronous single-port RAM, one cycle read latency, with bench preload hooks.
  always @(posedge clk_25) begin
    if (fill_en) begin
      for (int i = 0; i < 32768; i++) mem[i] <= fill_val;
    end else begin
      if (poke_en) mem[poke_addr] <= poke_val;
      if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
    end
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  typedef struct {
    logic              dr;
    logic [ADDR_W-1:0] da;
    logic              wv;
    logic [ADDR_W-1:0] wa;
    logic              wd;
    logic              e_rdy;
    logic              e_we;
    logic [ADDR_W-1:0] e_addr;
    logic              e_wdata;
    logic              e_dd;
  } vec_t;

  vec_t vecs [14];

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    bus.disp_req  = v.dr;
    bus.disp_addr = v.da;
    bus.wr_valid  = v.wv;
    bus.wr_addr   = v.wa;
    bus.wr_data   = v.wd;
  endtask

  task automatic next_cycle();
    @(posedge clk_25);
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    clr_start     = 1'b0;
    fill_en       = 1'b1;
    fill_val      = 1'b0;
    poke_en       = 1'b0;
    poke_addr     = '0;
    poke_val      = 1'b0;
    bus.disp_req  = 1'b0;
    bus.disp_addr = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = 1'b0;

    //            dr  da      wv  wa        wd  rdy we  addr      wdat dd
    vecs[0]  = '{1'b0, 15'd0,     1'b0, 15'd0,     1'b0, 1'b1, 1'b0, 15'd0,     1'b0, 1'b0};
    vecs[1]  = '{1'b1, 15'd5,     1'b0, 15'd0,     1'b0, 1'b0, 1'b0, 15'd5,     1'b0, 1'b0};
    vecs[2]  = '{1'b0, 15'd0,     1'b0, 15'd0,     1'b0, 1'b1, 1'b0, 15'd0,     1'b0, 1'b1};
    vecs[3]  = '{1'b0, 15'd0,     1'b0, 15'd0,     1'b0, 1'b1, 1'b0, 15'd0,     1'b0, 1'b0};
    vecs[4]  = '{1'b1, 15'd6,     1'b1, 15'd100,   1'b1, 1'b0, 1'b0, 15'd6,     1'b0, 1'b0};
    vecs[5]  = '{1'b1, 15'd6,     1'b1, 15'd100,   1'b1, 1'b0, 1'b0, 15'd6,     1'b0, 1'b0};
    vecs[6]  = '{1'b1, 15'd5,     1'b1, 15'd100,   1'b1, 1'b0, 1'b0, 15'd5,     1'b0, 1'b0};
    vecs[7]  = '{1'b0, 15'd0,     1'b1, 15'd100,   1'b1, 1'b1, 1'b1, 15'd100,   1'b1, 1'b1};
    vecs[8]  = '{1'b1, 15'd100,   1'b0, 15'd0,     1'b0, 1'b0, 1'b0, 15'd100,   1'b0, 1'b0};
    vecs[9]  = '{1'b0, 15'd0,     1'b1, 15'd19200, 1'b1, 1'b1, 1'b0, 15'd19200, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 15'd0,     1'b1, 15'd19199, 1'b1, 1'b1, 1'b1, 15'd19199, 1'b1, 1'b0};
    vecs[11] = '{1'b1, 15'd19199, 1'b0, 15'd0,     1'b0, 1'b0, 1'b0, 15'd19199, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 15'd3,     1'b0, 15'd0,     1'b0, 1'b1, 1'b0, 15'd3,     1'b0, 1'b1};
    vecs[13] = '{1'b0, 15'd0,     1'b1, 15'd200,   1'b0, 1'b1, 1'b1, 15'd200,   1'b0, 1'b0};

    next_cycle();
    fill_en   = 1'b0;
    poke_en   = 1'b1;
    poke_addr = 15'd5;
    poke_val  = 1'b1;
    next_cycle();
    poke_en = 1'b0;

    // Reset held: writer request must not reach the RAM.
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 15'd50;
    bus.wr_data  = 1'b1;
    #1;
    check_output("rst_wr_ready", bus.wr_ready, 0);
    check_output("rst_ram_we", bus.ram_we, 0);
    check_output("rst_disp_data", bus.disp_data, 0);
    check_output("rst_clr_busy", clr_busy, 0);
    check_output("rst_clr_done", clr_done, 0);
    next_cycle();
    bus.wr_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check_output("release_wr_ready", bus.wr_ready, 1);

    for (int i = 0; i < 14; i++) begin
      apply_stimulus(vecs[i]);
      #1;
      check_output($sformatf("v%0d_wr_ready", i), bus.wr_ready, vecs[i].e_rdy);
      check_output($sformatf("v%0d_ram_we", i), bus.ram_we, vecs[i].e_we);
      check_output($sformatf("v%0d_ram_addr", i), bus.ram_addr, vecs[i].e_addr);
      check_output($sformatf("v%0d_disp_data", i), bus.disp_data, vecs[i].e_dd);
      if (vecs[i].e_we) check_output($sformatf("v%0d_ram_wdata", i), bus.ram_wdata, vecs[i].e_wdata);
      next_cycle();
    end
    check_output("oob_write_dropped", mem[19200], 0);
    check_output("inrange_write_mem", mem[19199], 1);
    check_output("write_100_mem", mem[100], 1);

    // Reset asserted mid-traffic with a read pending and a write offered.
    bus.disp_req  = 1'b1;
    bus.disp_addr = 15'd5;
    bus.wr_valid  = 1'b0;
    next_cycle();
    bus.disp_req = 1'b0;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 15'd50;
    bus.wr_data  = 1'b1;
    #1;
    check_output("pre_reset_disp_data", bus.disp_data, 1);
    rst_n = 1'b0;
    #1;
    check_output("midrst_disp_data", bus.disp_data, 0);
    check_output("midrst_wr_ready", bus.wr_ready, 0);
    check_output("midrst_ram_we", bus.ram_we, 0);
    next_cycle();
    bus.wr_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    check_output("midrst_no_write", mem[50], 0);
    check_output("midrst_release_ready", bus.wr_ready, 1);
    next_cycle();

`ifndef FB_CLEAR_EN
    // Without the clear engine clr_start is inert and the writer keeps the port.
    clr_start    = 1'b1;
    bus.wr_valid = 1'b1;
    bus.wr_addr  = 15'd60;
    bus.wr_data  = 1'b1;
    #1;
    check_output("nclr_start_ready", bus.wr_ready, 1);
    check_output("nclr_start_we", bus.ram_we, 1);
    next_cycle();
    clr_start    = 1'b0;
    bus.wr_valid = 1'b0;
    #1;
    check_output("nclr_busy", clr_busy, 0);
    check_output("nclr_done", clr_done, 0);
    check_output("nclr_ready", bus.wr_ready, 1);
    next_cycle();
    check_output("nclr_write_60", mem[60], 1);
`else
    begin
      int          c;
      int          writes;
      int          seq_err;
      int          busy_err;
      int          done_cnt;
      int          extra_done;
      int          nonzero;
      int          found;
      logic [14:0] exp_a;

      fill_en  = 1'b1;
      fill_val = 1'b1;
      next_cycle();
      fill_en = 1'b0;

      // clr_start together with a write: the write wins this cycle.
      clr_start    = 1'b1;
      bus.wr_valid = 1'b1;
      bus.wr_addr  = 15'd10;
      bus.wr_data  = 1'b1;
      #1;
      check_output("clr_start_wr_ready", bus.wr_ready, 1);
      check_output("clr_start_ram_we", bus.ram_we, 1);
      check_output("clr_start_ram_addr", bus.ram_addr, 10);
      next_cycle();
      clr_start    = 1'b0;
      bus.wr_valid = 1'b0;

      c = 0; writes = 0; seq_err = 0; busy_err = 0; done_cnt = 0; exp_a = '0;
      while (done_cnt == 0 && c < 45000) begin
        bus.disp_req  = c[0];
        bus.disp_addr = 15'(c % DEPTH);
        bus.wr_valid  = 1'b1;
        bus.wr_addr   = 15'd20;
        #1;
        if (clr_done) begin
          done_cnt++;
          check_output("done_cycle_busy", clr_busy, 0);
        end else begin
          if (clr_busy !== 1'b1) busy_err++;
          if (bus.wr_ready !== 1'b0) busy_err++;
          if (bus.ram_we) begin
            writes++;
            if (bus.ram_addr !== exp_a || bus.ram_wdata !== 1'b0) seq_err++;
            exp_a = exp_a + 15'd1;
          end
        end
        next_cycle();
        c++;
      end
      bus.wr_valid = 1'b0;
      bus.disp_req = 1'b0;
      check_output("clear_done_seen", done_cnt, 1);
      check_output("clear_write_count", writes, DEPTH);
      check_output("clear_addr_seq_errors", seq_err, 0);
      check_output("clear_busy_ready_errors", busy_err, 0);

      extra_done = 0;
      for (int k = 0; k < 5; k++) begin
        #1;
        if (clr_done) extra_done++;
        next_cycle();
      end
      check_output("clr_done_single_pulse", extra_done, 0);
      check_output("post_clear_busy", clr_busy, 0);
      check_output("post_clear_ready", bus.wr_ready, 1);

      nonzero = 0;
      for (int a = 0; a < DEPTH; a++) if (mem[a] !== 1'b0) nonzero++;
      check_output("clear_nonzero_pixels", nonzero, 0);
      check_output("clear_beyond_depth", mem[DEPTH], 1);

      // Reset mid-clear at clr_addr 7000.
      fill_en = 1'b1;
      next_cycle();
      fill_en   = 1'b0;
      clr_start = 1'b1;
      next_cycle();
      clr_start = 1'b0;
      c = 0; found = 0;
      while (found == 0 && c < 10000) begin
        #1;
        if (bus.ram_we && bus.ram_addr == 15'd7000) found = 1;
        else begin
          next_cycle();
          c++;
        end
      end
      check_output("reached_addr_7000", found, 1);
      rst_n = 1'b0;
      #1;
      check_output("abort_clr_busy", clr_busy, 0);
      check_output("abort_clr_done", clr_done, 0);
      check_output("abort_ram_we", bus.ram_we, 0);
      extra_done = 0;
      for (int k = 0; k < 2; k++) begin
        next_cycle();
        if (clr_done) extra_done++;
      end
      rst_n = 1'b1;
      #1;
      if (clr_done) extra_done++;
      check_output("abort_no_done_pulse", extra_done, 0);
      check_output("abort_mem_7000", mem[7000], 1);
      check_output("abort_mem_6999", mem[6999], 0);
      next_cycle();

      clr_start = 1'b1;
      next_cycle();
      clr_start = 1'b0;
      #1;
      check_output("restart_addr", bus.ram_addr, 0);
      check_output("restart_we", bus.ram_we, 1);
      check_output("restart_busy", clr_busy, 1);
      next_cycle();
      clr_start = 1'b1;
      #1;
      check_output("restart_addr1", bus.ram_addr, 1);
      next_cycle();
      clr_start = 1'b0;
      #1;
      check_output("start_ignored_in_clear", bus.ram_addr, 2);
      rst_n = 1'b0;
      next_cycle();
      rst_n = 1'b1;
      next_cycle();
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
